alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- Keeps the same operation set: ADD/SUB via B inversion, AND, OR, XOR.
- Adds:
  - configurable operand width
  - valid/ready handshakes with backpressure
  - a 2-stage registered pipeline
  - a result accumulator usable as operand A
  - full flag set (carry, signed overflow, zero, negative) plus sticky overflow
- Sits between an instruction/operand source and a result consumer in the datapath.

---
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, backpressure and an accumulator.
// Performs ADD/SUB (B inversion), AND, OR and XOR, and produces carry, overflow, zero, negative and sticky-overflow flags.
module alu_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_inv,
   input  logic [1:0]       sel,
   input  logic             acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ov,
   output logic             zero,
   output logic             neg,
   output logic             ov_sticky
);

   localparam int unsigned MSB   = WIDTH - 1;
   localparam int unsigned SUM_W = WIDTH + 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_AND = 2'b01,
      OP_OR  = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             b_inv;
      op_e              op;
      logic             acc_sel;
   } s1_t;

   s1_t              s1_q;
   logic             s1_valid;
   logic [WIDTH-1:0] acc_q;

   logic             s2_load;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [SUM_W-1:0] sum;
   logic [WIDTH-1:0] c_res;
   logic             c_carry;
   logic             c_ov;

   // Handshake control: stage 1 frees up whenever its op moves into stage 2
   always_comb begin
      s2_load  = s1_valid && (!out_valid || out_ready);
      in_ready = !s1_valid || s2_load;
   end

   // Operand A is chosen at compute time so chained accumulator ops see the latest result
   always_comb begin
      op_a    = s1_q.acc_sel ? acc_q : s1_q.a;
      op_b    = s1_q.b_inv ? ~s1_q.b : s1_q.b;
      sum     = {1'b0, op_a} + {1'b0, op_b} + SUM_W'(s1_q.b_inv);
      c_res   = '0;
      c_carry = 1'b0;
      c_ov    = 1'b0;
      case (s1_q.op)
         OP_ADD: begin
            c_res   = sum[WIDTH-1:0];
            c_carry = sum[WIDTH];
            c_ov    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
         end
         OP_AND:  c_res = op_a & op_b;
         OP_OR:   c_res = op_a | op_b;
         OP_XOR:  c_res = op_a ^ op_b;
         default: c_res = '0;
      endcase
   end

   // Stage 1: operand capture
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         if (in_valid && in_ready) begin
            s1_valid     <= 1'b1;
            s1_q.a       <= a;
            s1_q.b       <= b;
            s1_q.b_inv   <= b_inv;
            s1_q.op      <= op_e'(sel);
            s1_q.acc_sel <= acc_sel;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: result and flag registers, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         ov        <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         result    <= c_res;
         carry     <= c_carry;
         ov        <= c_ov;
         zero      <= ~|c_res;
         neg       <= c_res[MSB];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Accumulator and sticky overflow; a clear pulse beats a concurrent update
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         ov_sticky <= 1'b0;
      end else begin
         if (acc_clr) begin
            acc_q <= '0;
         end else if (s2_load) begin
            acc_q <= c_res;
         end
         if (acc_clr) begin
            ov_sticky <= 1'b0;
         end else if (s2_load && c_ov) begin
            ov_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 4-bit and an 8-bit instance share stimulus buses.
// Directed ops push hand-computed expectations that the per-instance monitors pop on delivery.
module tb_alu_pipe;

   localparam int unsigned W4 = 4;
   localparam int unsigned W8 = 8;

   typedef struct packed {
      logic [7:0] res;
      logic       carry;
      logic       ov;
      logic       zero;
      logic       neg;
   } exp_t;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       iv4       = 1'b0;
   logic       iv8       = 1'b0;
   logic       out_ready = 1'b1;
   logic       b_inv     = 1'b0;
   logic       acc_sel   = 1'b0;
   logic       acc_clr   = 1'b0;
   logic [7:0] a         = 8'h00;
   logic [7:0] b         = 8'h00;
   logic [1:0] sel       = 2'b00;

   logic       in_ready4, out_valid4, carry4, ovf4, zero4, neg4, sticky4;
   logic [3:0] result4;
   logic       in_ready8, out_valid8, carry8, ovf8, zero8, neg8, sticky8;
   logic [7:0] result8;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q4[$];
   exp_t q8[$];
   int   dcyc8[$];
   exp_t e4, e8;
   logic        held_v = 1'b0;
   logic [11:0] held   = '0;
   int   n0;

   alu_pipe #(.WIDTH(W4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(in_ready4),
      .a(a[3:0]), .b(b[3:0]), .b_inv(b_inv), .sel(sel), .acc_sel(acc_sel), .acc_clr(acc_clr),
      .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
      .carry(carry4), .ov(ovf4), .zero(zero4), .neg(neg4), .ov_sticky(sticky4)
   );

   alu_pipe #(.WIDTH(W8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(in_ready8),
      .a(a), .b(b), .b_inv(b_inv), .sel(sel), .acc_sel(acc_sel), .acc_clr(acc_clr),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
      .carry(carry8), .ov(ovf8), .zero(zero8), .neg(neg8), .ov_sticky(sticky8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic c, input logic o,
                               input logic z, input logic n);
      return {r, c, o, z, n};
   endfunction

   // Monitor for the 4-bit instance: pop and compare on each handshake
   always @(negedge clk) begin
      if (!rst && out_valid4 && out_ready) begin
         if (q4.size() == 0) begin
            total++; bad++;
            $display("FAIL u4 unexpected: got %0h want none", result4);
         end else begin
            e4 = q4.pop_front();
            check("u4 out {res,c,v,z,n}", {8'(result4), carry4, ovf4, zero4, neg4}, e4);
         end
      end
   end

   // Monitor for the 8-bit instance: also checks stability across stall cycles
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else if (out_valid8) begin
         if (held_v) check("u8 stall hold", {result8, carry8, ovf8, zero8, neg8}, held);
         if (out_ready) begin
            held_v = 1'b0;
            dcyc8.push_back(cyc);
            if (q8.size() == 0) begin
               total++; bad++;
               $display("FAIL u8 unexpected: got %0h want none", result8);
            end else begin
               e8 = q8.pop_front();
               check("u8 out {res,c,v,z,n}", {result8, carry8, ovf8, zero8, neg8}, e8);
            end
         end else begin
            held_v = 1'b1;
            held   = {result8, carry8, ovf8, zero8, neg8};
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // Present one op to the chosen instance; returns just after its capture edge
   task automatic issue(input bit w8, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tinv, input logic [1:0] tsel, input logic tacc, input exp_t e);
      bit took;
      took = 1'b0;
      if (w8) q8.push_back(e); else q4.push_back(e);
      a = ta; b = tb; b_inv = tinv; sel = tsel; acc_sel = tacc;
      if (w8) iv8 = 1'b1; else iv4 = 1'b1;
      for (int i = 0; i < 40 && !took; i++) begin
         @(negedge clk);
         took = w8 ? in_ready8 : in_ready4;
         @(posedge clk); #1;
      end
      iv4 = 1'b0; iv8 = 1'b0;
      if (!took) begin
         total++; bad++;
         $display("FAIL issue timeout: got in_ready=0 want 1");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (q4.size() != 0 || q8.size() != 0); i++) @(posedge clk);
      #1;
      check("drain pending", 32'(q4.size() + q8.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_consec(input int start, input int n);
      for (int i = start + 1; i < start + n; i++) begin
         if (i < dcyc8.size()) check("u8 delivery gap", 32'(dcyc8[i] - dcyc8[i-1]), 1);
         else check("u8 delivery count", 32'(dcyc8.size()), 32'(start + n));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset in_ready4", in_ready4, 1);
      check("reset in_ready8", in_ready8, 1);
      check("reset out_valid", {out_valid4, out_valid8}, 0);
      check("reset result", {result4, result8}, 0);
      check("reset flags", {carry4, ovf4, zero4, neg4, carry8, ovf8, zero8, neg8}, 0);
      check("reset sticky", {sticky4, sticky8}, 0);
      @(posedge clk); #1;

      // 4-bit AND to zero, with latency check
      issue(0, 8'hA, 8'h5, 0, 2'b01, 0, mk(8'h0, 0, 0, 1, 0));
      @(negedge clk); check("u4 valid one cycle after capture", out_valid4, 0);
      @(negedge clk); check("u4 valid two cycles after capture", out_valid4, 1);
      @(posedge clk); #1;

      // 4-bit signed overflow and sticky flag
      issue(0, 8'h7, 8'h1, 0, 2'b00, 0, mk(8'h8, 0, 1, 0, 1));
      repeat (3) @(negedge clk);
      check("u4 sticky after ov", sticky4, 1);
      @(posedge clk); #1;

      // 4-bit subtract with and without borrow
      issue(0, 8'h3, 8'h5, 1, 2'b00, 0, mk(8'hE, 0, 0, 0, 1));
      issue(0, 8'h5, 8'h3, 1, 2'b00, 0, mk(8'h2, 1, 0, 0, 0));
      drain();

      // Accumulator chain on the 8-bit instance
      acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      check("u4 sticky cleared by acc_clr", sticky4, 0);
      n0 = dcyc8.size();
      issue(1, 8'h00, 8'h03, 0, 2'b00, 1, mk(8'h03, 0, 0, 0, 0));
      issue(1, 8'h00, 8'h03, 0, 2'b00, 1, mk(8'h06, 0, 0, 0, 0));
      issue(1, 8'h00, 8'h03, 0, 2'b00, 1, mk(8'h09, 0, 0, 0, 0));
      drain();
      check_consec(n0, 3);
      issue(1, 8'h00, 8'hFF, 0, 2'b11, 1, mk(8'hF6, 0, 0, 0, 1));
      drain();

      // Backpressure: four ops against a stalled consumer
      out_ready = 1'b0;
      n0 = dcyc8.size();
      issue(1, 8'd10, 8'd20, 0, 2'b00, 0, mk(8'h1E, 0, 0, 0, 0));
      issue(1, 8'hF0, 8'h3C, 0, 2'b01, 0, mk(8'h30, 0, 0, 0, 0));
      @(negedge clk);
      check("u8 in_ready with both stages full", in_ready8, 0);
      check("u8 out_valid while stalled", out_valid8, 1);
      check("u8 first result while stalled", result8, 32'h1E);
      @(posedge clk); #1;
      fork
         begin
            issue(1, 8'h0F, 8'hF0, 0, 2'b10, 0, mk(8'hFF, 0, 0, 0, 1));
            issue(1, 8'h05, 8'h05, 1, 2'b00, 0, mk(8'h00, 1, 0, 1, 0));
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check_consec(n0, 4);

      // Reset with both stages full and sticky overflow set
      out_ready = 1'b0;
      issue(1, 8'h7F, 8'h01, 0, 2'b00, 0, mk(8'h80, 0, 1, 0, 1));
      issue(1, 8'h11, 8'h22, 0, 2'b00, 0, mk(8'h33, 0, 0, 0, 0));
      @(negedge clk);
      check("u8 sticky before reset", sticky8, 1);
      check("u8 full before reset", in_ready8, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("u8 out_valid after reset", out_valid8, 0);
      check("u8 sticky after reset", sticky8, 0);
      check("u8 in_ready after reset", in_ready8, 1);
      rst = 1'b0;
      q4.delete();
      q8.delete();
      out_ready = 1'b1;
      issue(1, 8'h00, 8'h05, 0, 2'b00, 1, mk(8'h05, 0, 0, 0, 0));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
